lcd_win_ctrl: RTL and testbench
===============================

# lcd_win_ctrl

Parametrised image-window controller for the LCD path. It loads a 2^XB × 2^YB image of DW-bit pixels from instruction ROM into an internal buffer, then runs host commands on a 2×2 window: move, max/min/average fill, rotate, mirror and reload. On request it streams the whole buffer out to image RAM. It replaces the fixed 8×8 / 8-bit controller and adds a reload command, an illegal-command flag and a defined command handshake.

## Interface
- XB, 3, log2 image width (columns); X index is XB bits
- YB, 3, log2 image height (rows); Y index is YB bits
- DW, 8, pixel width in bits
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- cmd  in  4  command code
- cmd_valid  in  1  command qualifier
- IROM_Q  in  DW  ROM read data, combinational from IROM_A
- IROM_rd  out  1  ROM read enable
- IROM_A  out  XB+YB  ROM address, {Y,X}
- IRAM_valid  out  1  RAM write strobe
- IRAM_D  out  DW  RAM write data
- IRAM_A  out  XB+YB  RAM write address, {Y,X}
- busy  out  1  high: command not accepted
- done  out  1  sticky: write-out complete
- err  out  1  one-cycle pulse: illegal command accepted

## Operation
- Buffer: N = 2^(XB+YB) pixels, index {Y,X}.
- Window: pixels P0={Y-1,X-1}, P1={Y-1,X}, P2={Y,X-1}, P3={Y,X}. Position (X,Y) has range X∈[1,2^XB−1], Y∈[1,2^YB−1].
- Position reset/reload value: X=2^(XB−1), Y=2^(YB−1).
- States: LOAD, IDLE, EXEC, WRITE.
  - LOAD: IROM_rd=1. Each cycle stores buf[IROM_A]<=IROM_Q and increments IROM_A. When IROM_A=N−1 the block enters IDLE, with IROM_rd<=0 and busy<=0.
  - IDLE: accepts a command when cmd_valid && !busy. Every accepted command sets busy<=1 on the next edge. No other command is accepted while busy=1.
  - EXEC (1 cycle): the command is applied, then the block returns to IDLE with busy<=0.
  - WRITE: IRAM_valid=1 and IRAM_D=buf[IRAM_A], with IRAM_A counting 0..N−1, one pixel per cycle. After beat N−1 the block sets IRAM_valid<=0, busy<=0, done<=1 and returns to IDLE.
- Commands:
  - 0: write-out (go to WRITE).
  - 1 up, 2 down, 3 left, 4 right: saturate at the range bounds. A shift at a bound is a no-op but still takes 1 busy cycle.
  - 5 max, 6 min: all four window pixels take the max/min of P0..P3.
  - 7 average: all four take floor((P0+P1+P2+P3)/4). The sum is DW+2 bits wide, so there is no overflow.
  - 8 CCW rotate: P0<=P1, P1<=P3, P2<=P0, P3<=P2.
  - 9 CW rotate: P0<=P2, P1<=P0, P2<=P3, P3<=P1.
  - 10 mirror-X: P0<->P2, P1<->P3.
  - 11 mirror-Y: P0<->P1, P2<->P3.
  - 12 reload: clears done, resets the position, sets IROM_A<=0 and enters LOAD.
  - 13–15: illegal. Buffer and position are unchanged. err pulses for the EXEC cycle.
- done stays 1 until reset or reload. Commands remain legal after done; a second write-out re-streams the buffer.
- cmd and cmd_valid are ignored while busy=1 or in LOAD/WRITE.

## Timing
- Reset values: IROM_rd=1, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0, err=0, state=LOAD, position=centre.
- Reset has priority in any state, including mid-LOAD and mid-WRITE. The block restarts in LOAD on the first edge after reset falls.
- Load latency: N cycles after reset deassertion until busy=0.
- Non-write commands: accepted at edge t; busy=1 in cycle t+1; result visible and busy=0 at edge t+2.
- Write-out: accepted at t; beat k (IRAM_A=k) is presented in cycle t+1+k; done=1 and busy=0 in cycle t+1+N.
- Reload: accepted at t; IROM_rd=1 from cycle t+1; busy=0 after N more cycles.
- Address arithmetic uses the full XB+YB index. Window offsets are −(2^XB+1), −2^XB, −1, 0 from {Y,X}, never wrapping because X,Y ≥ 1.

## Test plan
- Reset, ROM holding buf[i]=i (XB=YB=3, DW=8) -> busy falls after 64 cycles. Write-out gives 64 beats with IRAM_A=IRAM_D=0..63, then done=1.
- From centre (4,4), issue 5 max -> buf[27],[28],[35],[36] all =36. Issue 7 average on values 1,2,3,5 -> all =2 (floor of 11/4).
- Issue 1 up ×5 from Y=4 -> Y saturates at 1. Then 8 CCW on window values 0,1,8,9 -> becomes 1,9,0,8.
- Window values 255,255,255,254 with 7 average -> 254, with no overflow. Repeat with DW=12, XB=4, YB=2 and max values 4095 -> 4095.
- Assert reset in WRITE at beat 20 -> IRAM_valid=0, done=0, busy=1, and LOAD restarts at IROM_A=0.
- Issue cmd 14 -> err pulses 1 cycle and the buffer is unchanged. Then cmd 12 with ROM changed to 63−i -> done clears, and the next write-out streams 63..0.

Source files
------------

// File: rtl/lcd_win_ctrl.sv
// Image-window controller: loads a 2^XB x 2^YB image from ROM, applies 2x2 window
// commands from the host and streams the whole buffer out to RAM on request.
module lcd_win_ctrl #(
    parameter int XB = 3,
    parameter int YB = 3,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [DW-1:0]    IROM_Q,
    output logic             IROM_rd,
    output logic [XB+YB-1:0] IROM_A,
    output logic             IRAM_valid,
    output logic [DW-1:0]    IRAM_D,
    output logic [XB+YB-1:0] IRAM_A,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int AW = XB + YB;
    localparam int N  = 1 << AW;
    localparam int SW = DW + 2;
    localparam logic [XB-1:0] X_MIN = XB'(1);
    localparam logic [XB-1:0] X_MAX = '1;
    localparam logic [XB-1:0] X_CTR = XB'(1 << (XB - 1));
    localparam logic [YB-1:0] Y_MIN = YB'(1);
    localparam logic [YB-1:0] Y_MAX = '1;
    localparam logic [YB-1:0] Y_CTR = YB'(1 << (YB - 1));
    localparam logic [AW-1:0] ROW   = AW'(1 << XB);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_t;
    typedef enum logic [3:0] {
        C_WRITE = 4'd0, C_UP, C_DOWN, C_LEFT, C_RIGHT, C_MAX, C_MIN, C_AVG,
        C_CCW, C_CW, C_MIRX, C_MIRY, C_RELOAD
    } cmd_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_q;
    logic [XB-1:0] x_q;
    logic [YB-1:0] y_q;
    logic [DW-1:0] mem_q [N];

    logic          accept, load_last, write_last, win_we;
    logic [AW-1:0] a0, a1, a2, a3, iram_a_nx;
    logic [DW-1:0] p0, p1, p2, p3, mx01, mx23, mx, mn01, mn23, mn, avg;
    logic [DW-1:0] nw0, nw1, nw2, nw3;
    logic [SW-1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here is defaulted first, so no latch is inferred.
    always_comb begin
        accept     = (state_q == S_IDLE) && cmd_valid && !busy;
        load_last  = (state_q == S_LOAD) && (IROM_A == '1);
        write_last = (state_q == S_WRITE) && (IRAM_A == '1);
        iram_a_nx  = (state_q == S_WRITE) ? IRAM_A + AW'(1) : '0;
        state_d    = state_q;
        case (state_q)
            S_LOAD:  if (load_last) state_d = S_IDLE;
            S_IDLE:  if (accept) begin
                if (cmd == C_WRITE)       state_d = S_WRITE;
                else if (cmd == C_RELOAD) state_d = S_LOAD;
                else                      state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_IDLE;
            S_WRITE: if (write_last) state_d = S_IDLE;
            default: state_d = S_LOAD;
        endcase
    end

    // Window addresses never wrap because X and Y are kept at or above 1.
    always_comb begin
        a3   = {y_q, x_q};
        a2   = a3 - AW'(1);
        a1   = a3 - ROW;
        a0   = a1 - AW'(1);
        p0   = mem_q[a0];
        p1   = mem_q[a1];
        p2   = mem_q[a2];
        p3   = mem_q[a3];
        mx01 = (p0 > p1) ? p0 : p1;
        mx23 = (p2 > p3) ? p2 : p3;
        mx   = (mx01 > mx23) ? mx01 : mx23;
        mn01 = (p0 < p1) ? p0 : p1;
        mn23 = (p2 < p3) ? p2 : p3;
        mn   = (mn01 < mn23) ? mn01 : mn23;
        sum  = SW'(p0) + SW'(p1) + SW'(p2) + SW'(p3);
        avg  = sum[SW-1:2];
        nw0 = p0; nw1 = p1; nw2 = p2; nw3 = p3;
        win_we = 1'b0;
        if (state_q == S_EXEC) begin
            win_we = 1'b1;
            case (cmd_q)
                C_MAX:   begin nw0 = mx;  nw1 = mx;  nw2 = mx;  nw3 = mx;  end
                C_MIN:   begin nw0 = mn;  nw1 = mn;  nw2 = mn;  nw3 = mn;  end
                C_AVG:   begin nw0 = avg; nw1 = avg; nw2 = avg; nw3 = avg; end
                C_CCW:   begin nw0 = p1;  nw1 = p3;  nw2 = p0;  nw3 = p2;  end
                C_CW:    begin nw0 = p2;  nw1 = p0;  nw2 = p3;  nw3 = p1;  end
                C_MIRX:  begin nw0 = p2;  nw1 = p3;  nw2 = p0;  nw3 = p1;  end
                C_MIRY:  begin nw0 = p1;  nw1 = p0;  nw2 = p3;  nw3 = p2;  end
                default: win_we = 1'b0;
            endcase
        end
    end

    // NOTE: the pixel buffer has no reset; LOAD rewrites every entry before any read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_LOAD) begin
                mem_q[IROM_A] <= IROM_Q;
            end else if (win_we) begin
                mem_q[a0] <= nw0;
                mem_q[a1] <= nw1;
                mem_q[a2] <= nw2;
                mem_q[a3] <= nw3;
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            IROM_rd    <= 1'b1;
            IROM_A     <= '0;
            IRAM_valid <= 1'b0;
            IRAM_D     <= '0;
            IRAM_A     <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            x_q        <= X_CTR;
            y_q        <= Y_CTR;
            cmd_q      <= '0;
        end else begin
            err <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    IROM_A <= IROM_A + AW'(1);
                    if (load_last) begin
                        IROM_rd <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                S_IDLE: if (accept) begin
                    busy  <= 1'b1;
                    cmd_q <= cmd;
                    if (cmd == C_WRITE) begin
                        IRAM_valid <= 1'b1;
                        IRAM_A     <= '0;
                        IRAM_D     <= mem_q[iram_a_nx];
                    end else if (cmd == C_RELOAD) begin
                        done    <= 1'b0;
                        x_q     <= X_CTR;
                        y_q     <= Y_CTR;
                        IROM_A  <= '0;
                        IROM_rd <= 1'b1;
                    end else if (cmd > C_RELOAD) begin
                        err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    busy <= 1'b0;
                    case (cmd_q)
                        C_UP:    if (y_q > Y_MIN) y_q <= y_q - YB'(1);
                        C_DOWN:  if (y_q < Y_MAX) y_q <= y_q + YB'(1);
                        C_LEFT:  if (x_q > X_MIN) x_q <= x_q - XB'(1);
                        C_RIGHT: if (x_q < X_MAX) x_q <= x_q + XB'(1);
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (write_last) begin
                        IRAM_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        IRAM_A <= iram_a_nx;
                        IRAM_D <= mem_q[iram_a_nx];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed self-checking bench for lcd_win_ctrl: default 8x8/8-bit instance plus a
// 16x4/12-bit instance for the wide-pixel average check.
module tb_lcd_win_ctrl;
    localparam int XB = 3, YB = 3, DW = 8, AW = 6, N = 64;
    localparam int XB2 = 4, YB2 = 2, DW2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cmd_valid;
    logic [3:0]    cmd;
    logic [DW-1:0] irom_q, iram_d;
    logic [AW-1:0] irom_a, iram_a;
    logic          irom_rd, iram_valid, busy, done, err;
    logic [DW-1:0] rom [N];
    logic [DW-1:0] exp_img [N];

    logic           reset2, cmd_valid2;
    logic [3:0]     cmd2;
    logic [DW2-1:0] irom_q2, iram_d2;
    logic [AW-1:0]  irom_a2, iram_a2;
    logic           irom_rd2, iram_valid2, busy2, done2, err2;
    logic [DW2-1:0] rom2 [N];

    int checks = 0;
    int failures = 0;

    assign irom_q  = rom[irom_a];
    assign irom_q2 = rom2[irom_a2];

    lcd_win_ctrl #(.XB(XB), .YB(YB), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(irom_q), .IROM_rd(irom_rd), .IROM_A(irom_a),
        .IRAM_valid(iram_valid), .IRAM_D(iram_d), .IRAM_A(iram_a),
        .busy(busy), .done(done), .err(err)
    );

    lcd_win_ctrl #(.XB(XB2), .YB(YB2), .DW(DW2)) dut2 (
        .clk(clk), .reset(reset2), .cmd(cmd2), .cmd_valid(cmd_valid2),
        .IROM_Q(irom_q2), .IROM_rd(irom_rd2), .IROM_A(irom_a2),
        .IRAM_valid(iram_valid2), .IRAM_D(iram_d2), .IRAM_A(iram_a2),
        .busy(busy2), .done(done2), .err(err2)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != N) begin
            failures++;
            $display("FAIL %s load_cycles: got %0d want %0d", tag, n, N);
        end
    endtask

    task automatic exec_cmd(input logic [3:0] c, input string tag);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_exec: got %b want 1", tag, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_release: got %b want 0", tag, busy);
        end
    endtask

    task automatic test_write_out(input string tag);
        logic [AW-1:0] ka;
        cmd = 4'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            ka = AW'(k);
            checks++;
            if (iram_valid !== 1'b1 || iram_a !== ka || iram_d !== exp_img[k]) begin
                failures++;
                $display("FAIL %s beat%0d: got valid=%b A=%0d D=%0d want valid=1 A=%0d D=%0d",
                         tag, k, iram_valid, iram_a, iram_d, ka, exp_img[k]);
            end
            tick();
        end
        checks++;
        if (iram_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s end: got valid=%b done=%b busy=%b want 0/1/0",
                     tag, iram_valid, done, busy);
        end
    endtask

    task automatic do_reload(input string tag);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_before: got %b want 1", tag, done);
        end
        cmd = 4'd12;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (irom_rd !== 1'b1 || irom_a !== 6'd0 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s reload_start: got rd=%b A=%0d done=%b busy=%b want 1/0/0/1",
                     tag, irom_rd, irom_a, done, busy);
        end
        wait_load(tag);
        for (int i = 0; i < N; i++) exp_img[i] = rom[i];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd = 4'd0;
        cmd_valid = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = DW'(i);
        tick();
        tick();
        checks++;
        if (irom_rd !== 1'b1 || irom_a !== 6'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rom: got rd=%b A=%0d busy=%b want 1/0/1", irom_rd, irom_a, busy);
        end
        checks++;
        if (iram_valid !== 1'b0 || iram_d !== 8'd0 || iram_a !== 6'd0) begin
            failures++;
            $display("FAIL reset_ram: got valid=%b D=%0d A=%0d want 0/0/0", iram_valid, iram_d, iram_a);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got done=%b err=%b want 0/0", done, err);
        end
        reset = 1'b0;
        wait_load("reset_load");
        checks++;
        if (irom_rd !== 1'b0) begin
            failures++;
            $display("FAIL load_rd_off: got %b want 0", irom_rd);
        end
        for (int i = 0; i < N; i++) exp_img[i] = DW'(i);
    endtask

    task automatic test_max_shift_ccw();
        exec_cmd(4'd5, "max");
        exp_img[27] = 8'd36; exp_img[28] = 8'd36; exp_img[35] = 8'd36; exp_img[36] = 8'd36;
        for (int i = 0; i < 5; i++) exec_cmd(4'd1, "up");
        for (int i = 0; i < 5; i++) exec_cmd(4'd3, "left");
        exec_cmd(4'd8, "ccw");
        exp_img[0] = 8'd1; exp_img[1] = 8'd9; exp_img[8] = 8'd0; exp_img[9] = 8'd8;
        test_write_out("max_ccw");
    endtask

    task automatic test_cw_mirror();
        exec_cmd(4'd9, "cw");
        exp_img[0] = 8'd0; exp_img[1] = 8'd1; exp_img[8] = 8'd8; exp_img[9] = 8'd9;
        for (int i = 0; i < 9; i++) exec_cmd(4'd4, "right");
        for (int i = 0; i < 9; i++) exec_cmd(4'd2, "down");
        exec_cmd(4'd10, "mirx");
        exec_cmd(4'd11, "miry");
        exp_img[54] = 8'd63; exp_img[55] = 8'd62; exp_img[62] = 8'd55; exp_img[63] = 8'd54;
        test_write_out("cw_mirror");
    endtask

    task automatic test_min_err();
        exec_cmd(4'd6, "min");
        exp_img[54] = 8'd54; exp_img[55] = 8'd54; exp_img[62] = 8'd54; exp_img[63] = 8'd54;
        cmd = 4'd14;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse: got err=%b busy=%b want 1/1", err, busy);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got err=%b busy=%b want 0/0", err, busy);
        end
        test_write_out("min_err");
    endtask

    task automatic test_reload();
        for (int i = 0; i < N; i++) rom[i] = DW'(63 - i);
        do_reload("reload");
        test_write_out("reload_stream");
    endtask

    task automatic test_average();
        for (int i = 0; i < N; i++) rom[i] = DW'(63 - i);
        rom[27] = 8'd1;   rom[28] = 8'd2;   rom[35] = 8'd3;   rom[36] = 8'd5;
        rom[29] = 8'd255; rom[30] = 8'd255; rom[37] = 8'd255; rom[38] = 8'd254;
        do_reload("avg_reload");
        exec_cmd(4'd7, "avg_small");
        exp_img[27] = 8'd2; exp_img[28] = 8'd2; exp_img[35] = 8'd2; exp_img[36] = 8'd2;
        exec_cmd(4'd4, "right");
        exec_cmd(4'd4, "right");
        exec_cmd(4'd7, "avg_big");
        exp_img[29] = 8'd254; exp_img[30] = 8'd254; exp_img[37] = 8'd254; exp_img[38] = 8'd254;
        test_write_out("average");
    endtask

    task automatic test_reset_in_write();
        int n = 0;
        cmd = 4'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        while (iram_a !== 6'd20 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (iram_a !== 6'd20 || iram_valid !== 1'b1) begin
            failures++;
            $display("FAIL beat20_reached: got A=%0d valid=%b want 20/1", iram_a, iram_valid);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (iram_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || irom_a !== 6'd0 || irom_rd !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_write: got valid=%b done=%b busy=%b romA=%0d rd=%b want 0/0/1/0/1",
                     iram_valid, done, busy, irom_a, irom_rd);
        end
        reset = 1'b0;
        wait_load("reset_mid_write_load");
        for (int i = 0; i < N; i++) exp_img[i] = rom[i];
        test_write_out("after_reset");
    endtask

    task automatic test_wide();
        int n = 0;
        logic [DW2-1:0] ev;
        logic [AW-1:0]  ka;
        for (int i = 0; i < N; i++) rom2[i] = DW2'(i);
        rom2[23] = 12'd4095; rom2[24] = 12'd4095; rom2[39] = 12'd4094; rom2[40] = 12'd4093;
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        while (busy2 === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != N) begin
            failures++;
            $display("FAIL wide_load_cycles: got %0d want %0d", n, N);
        end
        cmd2 = 4'd5; cmd_valid2 = 1'b1; tick(); cmd_valid2 = 1'b0; tick();
        cmd2 = 4'd7; cmd_valid2 = 1'b1; tick(); cmd_valid2 = 1'b0; tick();
        checks++;
        if (busy2 !== 1'b0) begin
            failures++;
            $display("FAIL wide_busy: got %b want 0", busy2);
        end
        cmd2 = 4'd0; cmd_valid2 = 1'b1; tick(); cmd_valid2 = 1'b0;
        for (int k = 0; k < N; k++) begin
            ka = AW'(k);
            ev = (k == 23 || k == 24 || k == 39 || k == 40) ? 12'd4095 : DW2'(k);
            checks++;
            if (iram_valid2 !== 1'b1 || iram_a2 !== ka || iram_d2 !== ev) begin
                failures++;
                $display("FAIL wide_beat%0d: got valid=%b A=%0d D=%0d want valid=1 A=%0d D=%0d",
                         k, iram_valid2, iram_a2, iram_d2, ka, ev);
            end
            tick();
        end
        checks++;
        if (done2 !== 1'b1 || err2 !== 1'b0) begin
            failures++;
            $display("FAIL wide_done: got done=%b err=%b want 1/0", done2, err2);
        end
    endtask

    initial begin
        reset2 = 1'b1;
        cmd2 = 4'd0;
        cmd_valid2 = 1'b0;
        test_reset();
        test_write_out("initial");
        test_max_shift_ccw();
        test_cw_mirror();
        test_min_err();
        test_reload();
        test_average();
        test_reset_in_write();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
